// File: rtl/commit_lanes_pkg.sv
// Shared codes and helpers for the commit_lanes MEM/WB commit register.
// Flush causes, stall bit positions, commit action decode and side-effect bundle.
package commit_lanes_pkg;

  typedef enum logic {
    CAUSE_EXCEPTION = 1'b0,
    CAUSE_OTHER     = 1'b1
  } flush_cause_e;

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } commit_act_e;

  localparam int STALL_MEM = 2;
  localparam int STALL_WB  = 3;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Lane-0 side effects that share one register bundle (CP0 data is kept apart,
  // its width follows DATA_W).
  typedef struct packed {
    logic       llbit;
    logic       llbit_we;
    logic       cp0_we;
    logic [4:0] cp0_waddr;
    logic [2:0] cp0_wsel;
  } side_ctl_t;

  // Only an exception flush acts here; other flush causes fall through to the
  // stall rules.
  function automatic commit_act_e decode_act(input logic       flush,
                                             input logic       flush_cause,
                                             input logic [3:0] stall);
    if (flush && (flush_cause_e'(flush_cause) == CAUSE_EXCEPTION))
      return ACT_FLUSH;
    else if (stall[STALL_MEM] && !stall[STALL_WB])
      return ACT_BUBBLE;
    else if (!stall[STALL_MEM])
      return ACT_ADVANCE;
    else
      return ACT_HOLD;
  endfunction

endpackage

// File: rtl/commit_lanes_waw_filter.sv
// Combinational write-enable filter: gates we by valid, kill and register 0,
// and keeps only the youngest surviving writer of each destination.
module commit_lanes_waw_filter
  import commit_lanes_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int ADDR_W = 5
) (
  input  logic [LANES-1:0]        kill,
  input  logic [LANES-1:0]        valid,
  input  logic [LANES-1:0]        we,
  input  logic [LANES*ADDR_W-1:0] waddr,
  output logic [LANES-1:0]        we_eff
);

  logic [LANES-1:0] live;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_live
      assign live[gi] = valid[gi] & we[gi] & ~kill[gi] &
                        (waddr[gi*ADDR_W +: ADDR_W] != ADDR_W'(NOP_REG_ADDR));
    end

    // A lane loses its write when any younger live lane targets the same register.
    for (gi = 0; gi < LANES; gi++) begin : g_keep
      logic shadowed;
      always_comb begin
        shadowed = 1'b0;
        for (int j = gi + 1; j < LANES; j++) begin
          if (live[j] && (waddr[j*ADDR_W +: ADDR_W] == waddr[gi*ADDR_W +: ADDR_W]))
            shadowed = 1'b1;
        end
      end
      assign we_eff[gi] = live[gi] & ~shadowed;
    end
  endgenerate

endmodule

// File: rtl/commit_lanes.sv
// Multi-lane MEM/WB commit register with precise exception cut, WAW collapse
// and retired-instruction counter (counter built only with COMMIT_RETIRE_CNT_EN).
module commit_lanes
  import commit_lanes_pkg::*;
#(
  parameter int  LANES  = 2,
  parameter int  DATA_W = 32,
  parameter int  ADDR_W = 5,
  parameter int  CNT_W  = 32,
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     flush_cause,
  input  logic [LANE_W-1:0]        exc_lane,
  input  logic [3:0]               stall,
  input  logic [LANES-1:0]         valid_i,
  input  logic [LANES-1:0]         we_i,
  input  logic [LANES*ADDR_W-1:0]  waddr_i,
  input  logic [LANES*DATA_W-1:0]  wdata_i,
  input  logic [LANES*DATA_W-1:0]  pc_i,
  input  logic                     llbit_i,
  input  logic                     llbit_we_i,
  input  logic                     cp0_we_i,
  input  logic [4:0]               cp0_waddr_i,
  input  logic [2:0]               cp0_wsel_i,
  input  logic [DATA_W-1:0]        cp0_wdata_i,
  output logic [LANES-1:0]         valid_o,
  output logic [LANES-1:0]         we_o,
  output logic [LANES*ADDR_W-1:0]  waddr_o,
  output logic [LANES*DATA_W-1:0]  wdata_o,
  output logic [LANES*DATA_W-1:0]  pc_o,
  output logic                     llbit_o,
  output logic                     llbit_we_o,
  output logic                     cp0_we_o,
  output logic [4:0]               cp0_waddr_o,
  output logic [2:0]               cp0_wsel_o,
  output logic [DATA_W-1:0]        cp0_wdata_o,
  output logic [CNT_W-1:0]         retire_cnt
);

  commit_act_e act;
  assign act = decode_act(flush, flush_cause, stall);

  logic [LANES-1:0]        kill;
  logic [LANES-1:0]        valid_next;
  logic [LANES-1:0]        we_next;
  logic [LANES*ADDR_W-1:0] waddr_next;
  logic [LANES*DATA_W-1:0] wdata_next;
  logic [LANES*DATA_W-1:0] pc_next;
  side_ctl_t               side_next;
  logic [DATA_W-1:0]       cp0_wdata_next;

  logic [LANES-1:0]        valid_reg;
  logic [LANES-1:0]        we_reg;
  logic [LANES*ADDR_W-1:0] waddr_reg;
  logic [LANES*DATA_W-1:0] wdata_reg;
  logic [LANES*DATA_W-1:0] pc_reg;
  side_ctl_t               side_reg;
  logic [DATA_W-1:0]       cp0_wdata_reg;

  genvar gi, gj;
  generate
    // The last lane is always cut: an out-of-range exc_lane behaves as LANES-1.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign kill[gi] = (act == ACT_FLUSH) &
                        ((exc_lane <= LANE_W'(gi)) | (gi == LANES - 1));

      assign valid_next[gi] = valid_i[gi] & ~kill[gi];
      assign waddr_next[gi*ADDR_W +: ADDR_W] =
        kill[gi] ? ADDR_W'(NOP_REG_ADDR) : waddr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_next[gi*DATA_W +: DATA_W] =
        kill[gi] ? DATA_W'(ZERO_WORD) : wdata_i[gi*DATA_W +: DATA_W];
      assign pc_next[gi*DATA_W +: DATA_W] =
        kill[gi] ? DATA_W'(ZERO_WORD) : pc_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  commit_lanes_waw_filter #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_waw_filter (
    .kill   (kill),
    .valid  (valid_i),
    .we     (we_i),
    .waddr  (waddr_i),
    .we_eff (we_next)
  );

  // Side effects belong to lane 0 and are dropped on any exception, whatever the cut.
  always_comb begin
    side_next      = '0;
    cp0_wdata_next = DATA_W'(ZERO_WORD);
    if (act == ACT_ADVANCE) begin
      side_next.llbit     = llbit_i;
      side_next.llbit_we  = llbit_we_i;
      side_next.cp0_we    = cp0_we_i;
      side_next.cp0_waddr = cp0_waddr_i;
      side_next.cp0_wsel  = cp0_wsel_i;
      cp0_wdata_next      = cp0_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg     <= '0;
      we_reg        <= '0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
      pc_reg        <= '0;
      side_reg      <= '0;
      cp0_wdata_reg <= '0;
    end else begin
      case (act)
        ACT_FLUSH, ACT_ADVANCE: begin
          valid_reg     <= valid_next;
          we_reg        <= we_next;
          waddr_reg     <= waddr_next;
          wdata_reg     <= wdata_next;
          pc_reg        <= pc_next;
          side_reg      <= side_next;
          cp0_wdata_reg <= cp0_wdata_next;
        end
        ACT_BUBBLE: begin
          valid_reg     <= '0;
          we_reg        <= '0;
          waddr_reg     <= '0;
          wdata_reg     <= '0;
          pc_reg        <= '0;
          side_reg      <= '0;
          cp0_wdata_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign valid_o     = valid_reg;
  assign we_o        = we_reg;
  assign waddr_o     = waddr_reg;
  assign wdata_o     = wdata_reg;
  assign pc_o        = pc_reg;
  assign llbit_o     = side_reg.llbit;
  assign llbit_we_o  = side_reg.llbit_we;
  assign cp0_we_o    = side_reg.cp0_we;
  assign cp0_waddr_o = side_reg.cp0_waddr;
  assign cp0_wsel_o  = side_reg.cp0_wsel;
  assign cp0_wdata_o = cp0_wdata_reg;

`ifdef COMMIT_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_add;
  logic [CNT_W-1:0] retire_cnt_reg;

  always_comb begin
    retire_add = '0;
    for (int k = 0; k < LANES; k++)
      retire_add = retire_add + CNT_W'(valid_next[k]);
  end

  // Counts only on edges that load new lane state; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retire_cnt_reg <= '0;
    else if ((act == ACT_FLUSH) || (act == ACT_ADVANCE))
      retire_cnt_reg <= retire_cnt_reg + retire_add;
  end

  assign retire_cnt = retire_cnt_reg;
`else
  assign retire_cnt = '0;
`endif

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_chk_lane
      a_we_implies_live: assert property (@(posedge clk) disable iff (!rst)
        we_reg[gi] |-> (valid_reg[gi] && (waddr_reg[gi*ADDR_W +: ADDR_W] != '0)));

      for (gj = gi + 1; gj < LANES; gj++) begin : g_chk_pair
        a_unique_dest: assert property (@(posedge clk) disable iff (!rst)
          !(we_reg[gi] && we_reg[gj] &&
            (waddr_reg[gi*ADDR_W +: ADDR_W] == waddr_reg[gj*ADDR_W +: ADDR_W])));
      end
    end
  endgenerate

endmodule
